pixel_arbiter_rr: RTL and testbench

- Parametrised successor of the fixed 7-iterator pixel arbiter.
- Arbitrates pixel-write requests from N_ITER iterators with round-robin fairness and issues single-cycle writes to the VGA SRAM port.
- Sequences the run: start pulse, plotting, all-done detection, elapsed-time report to the HPS.
- Sits between the iterator array and the VGA SRAM master; HPS reads elapsed_ms and done.

---
 rtl/pixel_arbiter_rr_if.sv | 28 ++
 rtl/pixel_arbiter_rr.sv | 142 ++++++++++++++
 tb/tb_pixel_arbiter_rr.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_arbiter_rr_if.sv
// Iterator-array and VGA SRAM write bus for pixel_arbiter_rr.
// master: arbiter side; slave: iterator array / SRAM side.
interface pixel_arbiter_rr_if #(
    parameter int N_ITER = 7,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 8
);
    logic [N_ITER*ADDR_W-1:0] iter_addr;
    logic [N_ITER*DATA_W-1:0] iter_data;
    logic [N_ITER-1:0]        iter_req;
    logic [N_ITER-1:0]        iter_done;
    logic [N_ITER-1:0]        iter_grant;
    logic [ADDR_W-1:0]        vga_sram_address;
    logic [DATA_W-1:0]        vga_sram_writedata;
    logic                     vga_sram_write;

    modport master (
        input  iter_addr, iter_data, iter_req, iter_done,
        output iter_grant, vga_sram_address,
        output vga_sram_writedata, vga_sram_write
    );

    modport slave (
        output iter_addr, iter_data, iter_req, iter_done,
        input  iter_grant, vga_sram_address,
        input  vga_sram_writedata, vga_sram_write
    );
endinterface

// File: rtl/pixel_arbiter_rr.sv
// Round-robin pixel-write arbiter and run sequencer for N_ITER iterators.
// Optional macro PIXEL_COUNT_EN adds a saturating written-pixel counter.
module pixel_arbiter_rr #(
    parameter int N_ITER      = 7,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 8,
    parameter int CLKS_PER_MS = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_n,
    input  logic                hps_start,
    pixel_arbiter_rr_if.master  bus,
    output logic                iter_start,
    output logic                hps_done,
    output logic [31:0]         elapsed_ms,
    output logic [31:0]         pixel_count
);
    localparam int PW = $clog2(N_ITER);
    localparam int CW = $clog2(CLKS_PER_MS + 1);

    typedef enum logic [2:0] {
        IDLE, START, RUN, ACK, DONE
    } state_t;

    state_t              state, next;
    logic [PW-1:0]       ptr, win;
    logic                win_ok, issue, start_cond;
    logic [CW-1:0]       cyc;
    logic [31:0]         ms;
    logic [N_ITER-1:0]   grant;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
    logic                wr;

    assign start_cond = !start_n || hps_start;
    assign issue      = (state == RUN) && win_ok;

    // Round-robin pick: first request at or after ptr+1, wrapping.
    always_comb begin : pick
        int sum;
        logic [PW-1:0] idx;
        sum    = 0;
        idx    = '0;
        win    = ptr;
        win_ok = 1'b0;
        for (int k = 1; k <= N_ITER; k++) begin
            sum = int'(ptr) + k;
            if (sum >= N_ITER) sum = sum - N_ITER;
            idx = PW'(sum);
            if (!win_ok && bus.iter_req[idx]) begin
                win_ok = 1'b1;
                win    = idx;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    // Next-state: a pending request always beats all-done.
    always_comb begin
        next = state;
        unique case (state)
            IDLE:    if (start_cond) next = START;
            START:   next = RUN;
            RUN: begin
                if (win_ok)                next = ACK;
                else if (&bus.iter_done)   next = DONE;
            end
            ACK:     next = RUN;
            DONE:    if (start_cond) next = START;
            default: next = IDLE;
        endcase
    end

    // Registered grant/write path, start pulse and done flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= PW'(N_ITER - 1);
            grant      <= '0;
            wr         <= 1'b0;
            addr       <= '0;
            data       <= '0;
            iter_start <= 1'b0;
            hps_done   <= 1'b0;
        end else begin
            iter_start <= (state == START);
            hps_done   <= (next == DONE);
            grant      <= '0;
            wr         <= 1'b0;
            if (issue) begin
                wr    <= 1'b1;
                grant <= N_ITER'(1) << win;
                ptr   <= win;
                addr  <= bus.iter_addr[int'(win)*ADDR_W +: ADDR_W];
                data  <= bus.iter_data[int'(win)*DATA_W +: DATA_W];
            end
        end
    end

    // Run timer: ms tick every CLKS_PER_MS cycles spent in RUN/ACK.
    always_ff @(posedge clk) begin
        if (reset || next == START) begin
            cyc        <= '0;
            ms         <= '0;
            elapsed_ms <= '0;
        end else begin
            if (state == RUN || state == ACK) begin
                if (cyc == CW'(CLKS_PER_MS - 1)) begin
                    cyc <= '0;
                    if (ms != '1) ms <= ms + 32'd1;
                end else begin
                    cyc <= cyc + CW'(1);
                end
            end
            if (state == RUN && next == DONE) elapsed_ms <= ms;
        end
    end

`ifdef PIXEL_COUNT_EN
    logic [31:0] pix;

    // Saturating count of issued writes, cleared on each new run.
    always_ff @(posedge clk) begin
        if (reset || next == START) pix <= '0;
        else if (issue && pix != '1) pix <= pix + 32'd1;
    end

    assign pixel_count = pix;
`else
    assign pixel_count = '0;
`endif

    assign bus.iter_grant         = grant;
    assign bus.vga_sram_write     = wr;
    assign bus.vga_sram_address   = addr;
    assign bus.vga_sram_writedata = data;
endmodule

// File: tb/tb_pixel_arbiter_rr.sv
// Directed testbench for pixel_arbiter_rr (N_ITER=7, CLKS_PER_MS=10).
// Inputs change 1ns after posedge; outputs are sampled at that point.
module tb_pixel_arbiter_rr;
    localparam int N = 7;
    localparam int AW = 32;
    localparam int DW = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_n;
    logic        hps_start;
    logic        iter_start;
    logic        hps_done;
    logic [31:0] elapsed_ms;
    logic [31:0] pixel_count;

    int errors = 0;
    int checks = 0;

    pixel_arbiter_rr_if #(.N_ITER(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    pixel_arbiter_rr #(
        .N_ITER(N), .ADDR_W(AW), .DATA_W(DW), .CLKS_PER_MS(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start_n(start_n),
        .hps_start(hps_start),
        .bus(bus),
        .iter_start(iter_start),
        .hps_done(hps_done),
        .elapsed_ms(elapsed_ms),
        .pixel_count(pixel_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start_n = 1'b1;
        hps_start = 1'b0;
        bus.iter_req = '0;
        bus.iter_done = '0;
        for (int i = 0; i < N; i++) begin
            bus.iter_addr[i*AW +: AW] = 32'hA000_0000 + 32'(i);
            bus.iter_data[i*DW +: DW] = 8'h10 + 8'(i);
        end
        tick();
        tick();
        checks++;
        if ({bus.vga_sram_write, bus.iter_grant, iter_start, hps_done} !== 10'd0) begin
            errors++;
            $display("FAIL reset_ctl got=%0h exp=0",
                {bus.vga_sram_write, bus.iter_grant, iter_start, hps_done});
        end
        checks++;
        if (bus.vga_sram_address !== 32'd0) begin
            errors++;
            $display("FAIL reset_addr got=%0h exp=0", bus.vga_sram_address);
        end
        checks++;
        if (elapsed_ms !== 32'd0 || pixel_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_cnt got=%0h/%0h exp=0/0", elapsed_ms, pixel_count);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (iter_start !== 1'b0) begin
            errors++;
            $display("FAIL idle_nostart got=%0b exp=0", iter_start);
        end
    endtask

    task automatic test_start();
        start_n = 1'b0;
        tick();
        start_n = 1'b1;
        checks++;
        if (iter_start !== 1'b0) begin
            errors++;
            $display("FAIL start_edge1 got=%0b exp=0", iter_start);
        end
        tick();
        checks++;
        if (iter_start !== 1'b1 || hps_done !== 1'b0) begin
            errors++;
            $display("FAIL start_edge2 got=%0b%0b exp=10", iter_start, hps_done);
        end
        tick();
        checks++;
        if (iter_start !== 1'b0) begin
            errors++;
            $display("FAIL start_once got=%0b exp=0", iter_start);
        end
    endtask

    task automatic test_rr_all();
        bus.iter_req = 7'h7f;
        for (int j = 0; j < N; j++) begin
            tick();
            checks++;
            if (bus.vga_sram_write !== 1'b1 || bus.iter_grant !== 7'(1 << j)) begin
                errors++;
                $display("FAIL rr_grant%0d got=%0b/%0h exp=1/%0h", j,
                    bus.vga_sram_write, bus.iter_grant, 7'(1 << j));
            end
            checks++;
            if (bus.vga_sram_address !== 32'hA000_0000 + 32'(j) ||
                bus.vga_sram_writedata !== 8'h10 + 8'(j)) begin
                errors++;
                $display("FAIL rr_slice%0d got=%0h/%0h exp=%0h/%0h", j,
                    bus.vga_sram_address, bus.vga_sram_writedata,
                    32'hA000_0000 + 32'(j), 8'h10 + 8'(j));
            end
            bus.iter_req[j] = 1'b0;
            tick();
            checks++;
            if (bus.vga_sram_write !== 1'b0 || bus.iter_grant !== 7'd0) begin
                errors++;
                $display("FAIL rr_gap%0d got=%0b/%0h exp=0/0", j,
                    bus.vga_sram_write, bus.iter_grant);
            end
            checks++;
            if (bus.vga_sram_address !== 32'hA000_0000 + 32'(j)) begin
                errors++;
                $display("FAIL rr_hold%0d got=%0h exp=%0h", j,
                    bus.vga_sram_address, 32'hA000_0000 + 32'(j));
            end
        end
    endtask

    task automatic test_wrap();
        bus.iter_req = 7'b0001000;
        tick();
        checks++;
        if (bus.iter_grant !== 7'b0001000) begin
            errors++;
            $display("FAIL wrap_ptr3 got=%0h exp=8", bus.iter_grant);
        end
        bus.iter_req = '0;
        tick();
        bus.iter_req = 7'b0100010;
        tick();
        checks++;
        if (bus.iter_grant !== 7'b0100000 ||
            bus.vga_sram_address !== 32'hA000_0005) begin
            errors++;
            $display("FAIL wrap_first got=%0h/%0h exp=20/a0000005",
                bus.iter_grant, bus.vga_sram_address);
        end
        bus.iter_req[5] = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.iter_grant !== 7'b0000010 ||
            bus.vga_sram_writedata !== 8'h11) begin
            errors++;
            $display("FAIL wrap_second got=%0h/%0h exp=2/11",
                bus.iter_grant, bus.vga_sram_writedata);
        end
        bus.iter_req = '0;
        tick();
    endtask

    task automatic test_done_priority();
        bus.iter_req = 7'b0000100;
        bus.iter_done = 7'h7f;
        tick();
        checks++;
        if (bus.vga_sram_write !== 1'b1 || bus.iter_grant !== 7'b0000100 ||
            hps_done !== 1'b0) begin
            errors++;
            $display("FAIL done_req_wins got=%0b/%0h/%0b exp=1/4/0",
                bus.vga_sram_write, bus.iter_grant, hps_done);
        end
        bus.iter_req = '0;
        tick();
        checks++;
        if (hps_done !== 1'b0) begin
            errors++;
            $display("FAIL done_early got=%0b exp=0", hps_done);
        end
        tick();
        checks++;
        if (hps_done !== 1'b1 || bus.vga_sram_write !== 1'b0) begin
            errors++;
            $display("FAIL done_entry got=%0b/%0b exp=1/0",
                hps_done, bus.vga_sram_write);
        end
    endtask

    task automatic test_timer();
        hps_start = 1'b1;
        bus.iter_done = '0;
        tick();
        hps_start = 1'b0;
        checks++;
        if (hps_done !== 1'b0 || elapsed_ms !== 32'd0) begin
            errors++;
            $display("FAIL restart1 got=%0b/%0d exp=0/0", hps_done, elapsed_ms);
        end
        tick();
        repeat (34) tick();
        bus.iter_done = 7'h7f;
        tick();
        checks++;
        if (hps_done !== 1'b1 || elapsed_ms !== 32'd3) begin
            errors++;
            $display("FAIL timer_ms got=%0b/%0d exp=1/3", hps_done, elapsed_ms);
        end
        repeat (5) tick();
        checks++;
        if (elapsed_ms !== 32'd3) begin
            errors++;
            $display("FAIL timer_hold got=%0d exp=3", elapsed_ms);
        end
        hps_start = 1'b1;
        bus.iter_done = '0;
        tick();
        hps_start = 1'b0;
        checks++;
        if (elapsed_ms !== 32'd0 || hps_done !== 1'b0) begin
            errors++;
            $display("FAIL restart2 got=%0d/%0b exp=0/0", elapsed_ms, hps_done);
        end
        tick();
        checks++;
        if (iter_start !== 1'b1) begin
            errors++;
            $display("FAIL hps_start_pulse got=%0b exp=1", iter_start);
        end
    endtask

    task automatic test_reset_in_ack();
        int ord[5] = '{3, 4, 0, 1, 2};
        logic [31:0] exp_pc;
`ifdef PIXEL_COUNT_EN
        exp_pc = 32'd5;
`else
        exp_pc = 32'd0;
`endif
        bus.iter_req = 7'b0011111;
        for (int n = 0; n < 5; n++) begin
            tick();
            checks++;
            if (bus.iter_grant !== 7'(1 << ord[n])) begin
                errors++;
                $display("FAIL pc_grant%0d got=%0h exp=%0h", n,
                    bus.iter_grant, 7'(1 << ord[n]));
            end
            bus.iter_req[ord[n]] = 1'b0;
            if (n < 4) tick();
        end
        checks++;
        if (pixel_count !== exp_pc) begin
            errors++;
            $display("FAIL pixel_count got=%0d exp=%0d", pixel_count, exp_pc);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({bus.vga_sram_write, bus.iter_grant, iter_start, hps_done} !== 10'd0 ||
            bus.vga_sram_address !== 32'd0 || bus.vga_sram_writedata !== 8'd0) begin
            errors++;
            $display("FAIL ack_reset got=%0b/%0h/%0h exp=0/0/0",
                bus.vga_sram_write, bus.iter_grant, bus.vga_sram_address);
        end
        checks++;
        if (pixel_count !== 32'd0 || elapsed_ms !== 32'd0) begin
            errors++;
            $display("FAIL ack_reset_cnt got=%0d/%0d exp=0/0",
                pixel_count, elapsed_ms);
        end
        bus.iter_req = 7'h7f;
        repeat (3) tick();
        checks++;
        if (bus.vga_sram_write !== 1'b0 || bus.iter_grant !== 7'd0 ||
            iter_start !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got=%0b/%0h/%0b exp=0/0/0",
                bus.vga_sram_write, bus.iter_grant, iter_start);
        end
        bus.iter_req = '0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_rr_all();
        test_wrap();
        test_done_priority();
        test_timer();
        test_reset_in_ack();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
